hist_eq_frame_sequencer: RTL and testbench

- Per-frame controller for the histogram-equalization pipeline.
- Watches the accepted pixel stream and gates histogram accumulation for exactly one frame.
- Then runs, in order: CDF build, scaled-histogram (LUT) calculation, ping-pong LUT bank swap, and histogram-RAM clear.
- Sits between the video input handshake and the histogram / CDF / scaled-histogram datapath blocks.

---
 rtl/hist_eq_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_hist_eq_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_frame_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hist_eq_frame_sequencer                                                       |
// | Per-frame control: gate one frame of histogram accumulation, then run the    |
// | CDF build, scaled-LUT calculation, ping-pong LUT bank swap and bin clear.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module hist_eq_frame_sequencer #(
  parameter int DataWidth    = 8,
  parameter int NumPixels    = 307200,
  parameter int inWidth      = $clog2(NumPixels),
  parameter int NumIntLevels = 2**DataWidth,
  parameter int CalcCycles   = NumIntLevels + 2,
  parameter int CdfTimeout   = 4 * NumIntLevels
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_pix_valid,
  input  logic                 i_pix_ready,
  input  logic                 i_pix_sof,
  input  logic                 i_cdf_done,
  output logic                 o_hist_en,
  output logic                 o_hist_clr,
  output logic [DataWidth-1:0] o_hist_clr_addr,
  output logic                 o_cdf_start,
  output logic                 o_start_calc,
  output logic                 o_lut_bank,
  output logic                 o_lut_swap,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_cdf_timeout,
  output logic [15:0]          o_frames_done
);

  localparam int c_TMR_W = $clog2(CdfTimeout + CalcCycles + 1);

  localparam logic [2:0] c_ST_CLEAR = 3'd0;
  localparam logic [2:0] c_ST_IDLE  = 3'd1;
  localparam logic [2:0] c_ST_ACCUM = 3'd2;
  localparam logic [2:0] c_ST_CDF   = 3'd3;
  localparam logic [2:0] c_ST_SCALE = 3'd4;
  localparam logic [2:0] c_ST_SWAP  = 3'd5;

  logic [2:0]           r_state;
  logic [DataWidth-1:0] r_clr_addr;
  logic [inWidth-1:0]   r_pix_cnt;
  logic [c_TMR_W-1:0]   r_timer;
  logic                 r_lut_bank;
  logic                 r_frame_err;
  logic                 r_cdf_timeout;
  logic [15:0]          r_frames_done;

  logic w_accept;
  logic w_last_pix;
  logic w_last_bin;
  logic w_cdf_expired;

  assign w_accept      = i_pix_valid && i_pix_ready;
  assign w_last_pix    = (r_pix_cnt == inWidth'(NumPixels - 1));
  assign w_last_bin    = (r_clr_addr == DataWidth'(NumIntLevels - 1));
  assign w_cdf_expired = (r_timer == c_TMR_W'(CdfTimeout - 1));

  // A sof inside ACCUM aborts the frame, so that pixel must not reach the histogram.
  assign o_hist_en       = w_accept && (((r_state == c_ST_IDLE) && i_pix_sof) ||
                                        ((r_state == c_ST_ACCUM) && !i_pix_sof));
  assign o_hist_clr      = (r_state == c_ST_CLEAR);
  assign o_hist_clr_addr = r_clr_addr;
  assign o_cdf_start     = (r_state == c_ST_CDF) && (r_timer == '0);
  assign o_start_calc    = (r_state == c_ST_SCALE) && (r_timer == c_TMR_W'(CalcCycles - 1));
  assign o_lut_swap      = (r_state == c_ST_SWAP);
  assign o_lut_bank      = r_lut_bank;
  assign o_busy          = (r_state != c_ST_IDLE) && (r_state != c_ST_ACCUM);
  assign o_frame_err     = r_frame_err;
  assign o_cdf_timeout   = r_cdf_timeout;
  assign o_frames_done   = r_frames_done;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= c_ST_CLEAR;
      r_clr_addr    <= '0;
      r_pix_cnt     <= '0;
      r_timer       <= '0;
      r_lut_bank    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_cdf_timeout <= 1'b0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        c_ST_CLEAR: begin
          r_clr_addr <= w_last_bin ? '0 : r_clr_addr + DataWidth'(1);
          if (w_last_bin) r_state <= c_ST_IDLE;
        end
        c_ST_IDLE: begin
          if (w_accept && i_pix_sof) begin
            r_state   <= c_ST_ACCUM;
            r_pix_cnt <= inWidth'(1);
          end
        end
        c_ST_ACCUM: begin
          if (w_accept) begin
            if (i_pix_sof) begin
              r_frame_err <= 1'b1;
              r_pix_cnt   <= '0;
              r_state     <= c_ST_CLEAR;
            end else if (w_last_pix) begin
              r_pix_cnt <= '0;
              r_timer   <= '0;
              r_state   <= c_ST_CDF;
            end else begin
              r_pix_cnt <= r_pix_cnt + inWidth'(1);
            end
          end
        end
        c_ST_CDF: begin
          if (i_cdf_done) begin
            r_timer <= c_TMR_W'(CalcCycles - 1);
            r_state <= c_ST_SCALE;
          end else if (w_cdf_expired) begin
            r_cdf_timeout <= 1'b1;
            r_timer       <= '0;
            r_state       <= c_ST_CLEAR;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end
        c_ST_SCALE: begin
          // Bank flips on entry to SWAP so bank and swap pulse line up in one cycle.
          if (r_timer == '0) begin
            r_lut_bank    <= ~r_lut_bank;
            r_frames_done <= r_frames_done + 16'd1;
            r_state       <= c_ST_SWAP;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end
        c_ST_SWAP: r_state <= c_ST_CLEAR;
        default:   r_state <= c_ST_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hist_eq_frame_sequencer.sv
`default_nettype none
// Bench for hist_eq_frame_sequencer: frame-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hist_eq_frame_sequencer;
  localparam int DW = 2;
  localparam int NP = 16;
  localparam int NL = 4;
  localparam int CC = 6;
  localparam int TO = 16;

  localparam int M_CLR = 0, M_IDLE = 1, M_ACC = 2, M_CDF = 3, M_SCALE = 4, M_SWAP = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, ready = 1'b0, sof = 1'b0, done = 1'b0;
  logic          hist_en, hist_clr, cdf_start, start_calc, lut_bank, lut_swap, busy, frame_err, cdf_timeout;
  logic [DW-1:0] clr_addr;
  logic [15:0]   frames_done;

  hist_eq_frame_sequencer #(.DataWidth(DW), .NumPixels(NP)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pix_valid(valid), .i_pix_ready(ready),
    .i_pix_sof(sof), .i_cdf_done(done), .o_hist_en(hist_en), .o_hist_clr(hist_clr),
    .o_hist_clr_addr(clr_addr), .o_cdf_start(cdf_start), .o_start_calc(start_calc),
    .o_lut_bank(lut_bank), .o_lut_swap(lut_swap), .o_busy(busy), .o_frame_err(frame_err),
    .o_cdf_timeout(cdf_timeout), .o_frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model
  int m_ph = M_CLR, m_clr_left = NL, m_pix = 0, m_age = 0, m_calc = 0;
  logic m_bank = 1'b0, m_err = 1'b0, m_tout = 1'b0;
  logic [15:0] m_frames = '0;

  // Monitor counters and cycle stamps
  int cyc = 0, n_hen = 0, n_clr = 0, n_cdfs = 0, n_calc = 0, n_swap = 0;
  int c_hen = -1, c_cdfs = -1, c_calc = -1, c_swap = -1, c_tout = -1;
  logic [DW-1:0] clr_q[$];

  logic          acc, e_clr, e_hen, e_cs, e_sc, e_sw, e_busy;
  logic [DW-1:0] e_addr;
  logic [26:0]   exp_v, act_v;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ph = M_CLR; m_clr_left = NL; m_pix = 0; m_age = 0; m_calc = 0;
      m_bank = 1'b0; m_err = 1'b0; m_tout = 1'b0; m_frames = '0;
    end
    acc    = valid && ready;
    e_clr  = (m_ph == M_CLR);
    e_addr = DW'(NL - m_clr_left);
    e_hen  = acc && (((m_ph == M_IDLE) && sof) || ((m_ph == M_ACC) && !sof));
    e_cs   = (m_ph == M_CDF) && (m_age == 0);
    e_sc   = (m_ph == M_SCALE) && (m_calc == 0);
    e_sw   = (m_ph == M_SWAP);
    e_busy = !((m_ph == M_IDLE) || (m_ph == M_ACC));
    exp_v  = {e_clr, e_addr, e_hen, e_cs, e_sc, m_bank, e_sw, e_busy, m_err, m_tout, m_frames};
    act_v  = {hist_clr, clr_addr, hist_en, cdf_start, start_calc, lut_bank, lut_swap, busy,
              frame_err, cdf_timeout, frames_done};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle_model cyc=%0d: got %h, expected %h", cyc, act_v, exp_v);
    end
    if (rst_n) begin
      if (hist_en)    begin n_hen++;  c_hen = cyc;  end
      if (hist_clr)   begin n_clr++;  clr_q.push_back(clr_addr); end
      if (cdf_start)  begin n_cdfs++; c_cdfs = cyc; end
      if (start_calc) begin n_calc++; c_calc = cyc; end
      if (lut_swap)   begin n_swap++; c_swap = cyc; end
      if (cdf_timeout && c_tout < 0) c_tout = cyc;
      case (m_ph)
        M_CLR: begin
          m_clr_left--;
          if (m_clr_left == 0) begin m_ph = M_IDLE; m_clr_left = NL; end
        end
        M_IDLE: if (acc && sof) begin m_ph = M_ACC; m_pix = 1; end
        M_ACC: if (acc) begin
          if (sof) begin m_err = 1'b1; m_ph = M_CLR; end
          else begin
            m_pix++;
            if (m_pix == NP) begin m_ph = M_CDF; m_age = 0; end
          end
        end
        M_CDF: begin
          if (done) begin m_ph = M_SCALE; m_calc = 0; end
          else begin
            m_age++;
            if (m_age == TO) begin m_tout = 1'b1; m_ph = M_CLR; end
          end
        end
        M_SCALE: begin
          m_calc++;
          if (m_calc == CC) begin m_bank = ~m_bank; m_frames++; m_ph = M_SWAP; end
        end
        default: m_ph = M_CLR;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    valid = 1'b0; ready = 1'b0; sof = 1'b0; done = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int sof_at, input bit toggle);
    for (int i = 0; i < npix; i++) begin
      valid = 1'b1; ready = 1'b1; sof = (i == 0) || (i == sof_at);
      step();
      if (toggle) begin ready = 1'b0; sof = 1'b0; step(); end
    end
    idle_in();
  endtask

  task automatic wait_cdf(input int n0);
    for (int k = 0; k < 50 && n_cdfs == n0; k++) step();
    check("cdf_start_seen", longint'(n_cdfs != n0), 1);
  endtask

  // Called one cycle after o_cdf_start; raises done d cycles after it.
  task automatic done_after(input int d);
    repeat (d - 1) step();
    done = 1'b1; step(); done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && busy; k++) step();
    check(name, longint'(busy), 0);
  endtask

  task automatic full_frame();
    int n0;
    n0 = n_cdfs;
    send_frame(NP, -1, 1'b0);
    wait_cdf(n0);
    done_after(5);
    wait_idle("full_frame_idle");
  endtask

  int h0, c0, n0, s0, w0;
  logic [15:0] f0;
  logic b0;

  initial begin
    idle_in();
    repeat (3) step();
    check("rst_bank", lut_bank, 0);
    check("rst_frames", frames_done, 0);
    check("rst_err", frame_err, 0);
    clr_q.delete();
    rst_n = 1'b1;
    wait_idle("boot_idle");
    check("boot_clr_len", clr_q.size(), 4);
    for (int i = 0; i < 4 && i < clr_q.size(); i++) check("boot_clr_addr", clr_q[i], i);
    check("boot_bank", lut_bank, 0);

    // Basic frame, done 5 cycles after cdf_start
    h0 = n_hen; n0 = n_cdfs;
    send_frame(NP, -1, 1'b0);
    wait_cdf(n0);
    c0 = n_clr;
    done_after(5);
    wait_idle("f1_idle");
    check("f1_hist_en", n_hen - h0, 16);
    check("f1_calc_lat", c_calc - c_cdfs, 6);
    check("f1_swap_lat", c_swap - c_cdfs, 12);
    check("f1_bank", lut_bank, 1);
    check("f1_frames", frames_done, 1);
    check("f1_clears", n_clr - c0, 4);

    // Ready toggling 1,0,1,0
    h0 = n_hen; n0 = n_cdfs;
    send_frame(NP, -1, 1'b1);
    wait_cdf(n0);
    check("f2_cdf_after_last", c_cdfs - c_hen, 1);
    done_after(5);
    wait_idle("f2_idle");
    check("f2_hist_en", n_hen - h0, 16);
    check("f2_bank", lut_bank, 0);
    check("f2_frames", frames_done, 2);

    // Early sof on accepted pixel 9
    h0 = n_hen; s0 = n_calc;
    send_frame(10, 9, 1'b0);
    check("err_hist_en", n_hen - h0, 9);
    wait_idle("err_idle");
    check("err_flag", frame_err, 1);
    check("err_bank", lut_bank, 0);
    check("err_no_calc", n_calc - s0, 0);
    h0 = n_hen;
    full_frame();
    check("err_next_hist_en", n_hen - h0, 16);
    check("err_next_frames", frames_done, 3);
    check("err_next_bank", lut_bank, 1);

    // Reset in the middle of accumulation
    valid = 1'b1; ready = 1'b1; sof = 1'b1; step();
    sof = 1'b0; repeat (4) step();
    rst_n = 1'b0; idle_in(); step(); step();
    check("mid_rst_bank", lut_bank, 0);
    check("mid_rst_frames", frames_done, 0);
    check("mid_rst_err", frame_err, 0);
    check("mid_rst_busy", busy, 1);
    rst_n = 1'b1;
    wait_idle("mid_rst_idle");

    // CDF timeout
    s0 = n_calc; w0 = n_swap; n0 = n_cdfs; c_tout = -1;
    send_frame(NP, -1, 1'b0);
    wait_cdf(n0);
    wait_idle("tout_idle");
    check("tout_flag", cdf_timeout, 1);
    check("tout_lat", c_tout - c_cdfs, 16);
    check("tout_no_calc", n_calc - s0, 0);
    check("tout_no_swap", n_swap - w0, 0);
    check("tout_frames", frames_done, 0);
    full_frame();
    check("tout_next_frames", frames_done, 1);
    check("tout_next_bank", lut_bank, 1);

    // Second frame arrives during SCALE, third in IDLE
    f0 = frames_done; b0 = lut_bank; n0 = n_cdfs;
    send_frame(NP, -1, 1'b0);
    wait_cdf(n0);
    done_after(5);
    h0 = n_hen;
    send_frame(NP, -1, 1'b0);
    wait_idle("ovl_idle");
    check("ovl_ignored", n_hen - h0, 0);
    h0 = n_hen;
    full_frame();
    check("ovl_third_hist_en", n_hen - h0, 16);
    check("ovl_frames", frames_done, longint'(f0 + 16'd2));
    check("ovl_bank", lut_bank, longint'(b0));

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
